// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue request and hazard response bundle between decode logic and hazard_scoreboard.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_BITS  = 5,
   parameter int unsigned CNT_BITS  = 4,
   parameter int unsigned PERF_BITS = 16
);
   localparam int unsigned NUM_REGS = 2 ** REG_BITS;

   logic                  issue_valid;
   logic [REG_BITS-1:0]   issue_rs;
   logic [REG_BITS-1:0]   issue_rt;
   logic                  issue_use_rs;
   logic                  issue_use_rt;
   logic                  issue_we;
   logic [REG_BITS-1:0]   issue_rd;
   logic [CNT_BITS-1:0]   issue_lat;
   logic                  stall;
   logic                  pc_write;
   logic                  ifid_write;
   logic                  idex_bubble;
   logic [NUM_REGS-1:0]   pending_mask;
   logic [PERF_BITS-1:0]  stall_count;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
             issue_we, issue_rd, issue_lat,
      input  stall, pc_write, ifid_write, idex_bubble, pending_mask, stall_count
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
             issue_we, issue_rd, issue_lat,
      output stall, pc_write, ifid_write, idex_bubble, pending_mask, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard/stall controller: per-register countdown scoreboard covering RAW, WAW
// and single-writeback-port conflicts for variable-latency units, plus a stall counter.
module hazard_scoreboard #(
   parameter int unsigned REG_BITS  = 5,
   parameter int unsigned MAX_LAT   = 8,
   parameter int unsigned CNT_BITS  = 4,
   parameter int unsigned PERF_BITS = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   hazard_scoreboard_if.slave   bus
);
   localparam int unsigned NUM_REGS = 2 ** REG_BITS;
   localparam logic [CNT_BITS-1:0] MAX_LAT_C = CNT_BITS'(MAX_LAT);

   logic [CNT_BITS-1:0]  cnt_q [NUM_REGS];
   logic [CNT_BITS-1:0]  cnt_d [NUM_REGS];
   logic [MAX_LAT:1]     wb_busy_q, wb_busy_d;
   logic [NUM_REGS-1:0]  pending_q, pending_d;
   logic [PERF_BITS-1:0] stall_count_q, stall_count_d;

   logic [CNT_BITS-1:0]  lat_eff;
   logic                 tracked_write;
   logic                 raw_hit, waw_hit, port_hit;
   logic                 stall_c, accept;

   // Hazard detection against current scoreboard state
   always_comb begin
      lat_eff       = (bus.issue_lat > MAX_LAT_C) ? MAX_LAT_C : bus.issue_lat;
      tracked_write = bus.issue_we && (bus.issue_rd != '0) && (bus.issue_lat != '0);
      raw_hit       = (bus.issue_use_rs && (cnt_q[bus.issue_rs] != '0)) ||
                      (bus.issue_use_rt && (cnt_q[bus.issue_rt] != '0));
      waw_hit       = tracked_write && (cnt_q[bus.issue_rd] > lat_eff);
      port_hit      = 1'b0;
      for (int unsigned i = 1; i <= MAX_LAT; i++) begin
         if ((lat_eff == CNT_BITS'(i)) && wb_busy_q[i]) port_hit = tracked_write;
      end
      stall_c = bus.issue_valid && (raw_hit || waw_hit || port_hit);
      accept  = bus.issue_valid && !stall_c;
   end

   // Next-state: countdowns, writeback reservation ring, saturating stall counter
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (accept && tracked_write && (bus.issue_rd == REG_BITS'(r))) begin
            cnt_d[r] = lat_eff;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - CNT_BITS'(1);
         end
         pending_d[r] = (cnt_d[r] != '0);
      end

      wb_busy_d = '0;
      for (int unsigned i = 1; i < MAX_LAT; i++) begin
         wb_busy_d[i] = wb_busy_q[i+1];
         // An L == 1 reservation would land on bit 0, i.e. it is already consumed
         if (accept && tracked_write && (lat_eff == CNT_BITS'(i + 1))) wb_busy_d[i] = 1'b1;
      end

      stall_count_d = stall_count_q;
      if (stall_c && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_BITS'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
         wb_busy_q     <= '0;
         pending_q     <= '0;
         stall_count_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
         wb_busy_q     <= wb_busy_d;
         pending_q     <= pending_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.stall        = stall_c;
   assign bus.pc_write     = ~stall_c;
   assign bus.ifid_write   = ~stall_c;
   assign bus.idex_bubble  = stall_c;
   assign bus.pending_mask = pending_q;
   assign bus.stall_count  = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: absolute-time reference model, directed scenarios and random traffic.
module tb_hazard_scoreboard;
   localparam int unsigned REG_BITS  = 5;
   localparam int unsigned MAX_LAT   = 8;
   localparam int unsigned CNT_BITS  = 4;
   localparam int unsigned PERF_BITS = 10;
   localparam int unsigned NUM_REGS  = 2 ** REG_BITS;
   localparam int unsigned SAT       = 2 ** PERF_BITS - 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   hazard_scoreboard_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS), .PERF_BITS(PERF_BITS)) bus ();

   hazard_scoreboard #(.REG_BITS(REG_BITS), .MAX_LAT(MAX_LAT), .CNT_BITS(CNT_BITS),
                       .PERF_BITS(PERF_BITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit v, urs, urt, we;
      int unsigned rs, rt, rd, lat;
   } ins_t;

   typedef struct {
      bit          stall;
      logic [31:0] pend;
      int unsigned scnt;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference model: register r becomes readable at absolute cycle ready_at[r];
   // resv holds absolute cycles whose writeback slot is already claimed.
   int unsigned now_c = 0;
   int unsigned ready_at [NUM_REGS];
   bit          resv [int unsigned];
   int unsigned m_scnt = 0;

   function automatic int unsigned m_cnt(int unsigned r);
      if (r == 0 || ready_at[r] <= now_c) return 0;
      return ready_at[r] - now_c;
   endfunction

   function automatic int unsigned eff(int unsigned lat);
      return (lat > MAX_LAT) ? MAX_LAT : lat;
   endfunction

   function automatic bit tracked(ins_t x);
      return x.we && x.rd != 0 && x.lat != 0;
   endfunction

   function automatic bit m_stall(ins_t x);
      int unsigned l = eff(x.lat);
      bit raw  = (x.urs && m_cnt(x.rs) != 0) || (x.urt && m_cnt(x.rt) != 0);
      bit waw  = tracked(x) && m_cnt(x.rd) > l;
      bit port = tracked(x) && resv.exists(now_c + l);
      return x.v && (raw || waw || port);
   endfunction

   function automatic ins_t mk(bit v, int unsigned rs, int unsigned rt, bit urs, bit urt,
                               bit we, int unsigned rd, int unsigned lat);
      ins_t x;
      x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
      x.we = we; x.rd = rd; x.lat = lat;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // One cycle: drive inputs, predict, push expectation, advance model past the coming edge
   task automatic step(input ins_t x, input bit rst_n, input bit do_chk, output bit dut_st);
      exp_t        e;
      bit          st;
      int unsigned l;
      @(posedge clock);
      #1;
      reset            = rst_n;
      bus.issue_valid  = x.v;
      bus.issue_rs     = REG_BITS'(x.rs);
      bus.issue_rt     = REG_BITS'(x.rt);
      bus.issue_use_rs = x.urs;
      bus.issue_use_rt = x.urt;
      bus.issue_we     = x.we;
      bus.issue_rd     = REG_BITS'(x.rd);
      bus.issue_lat    = CNT_BITS'(x.lat);
      st = m_stall(x);
      l  = eff(x.lat);
      if (do_chk) begin
         e.stall = st;
         e.pend  = '0;
         for (int r = 1; r < int'(NUM_REGS); r++) e.pend[r] = (m_cnt(r) != 0);
         e.scnt  = m_scnt;
         e.cyc   = now_c;
         exp_q.push_back(e);
      end
      if (!rst_n) begin
         for (int r = 0; r < int'(NUM_REGS); r++) ready_at[r] = 0;
         resv.delete();
         m_scnt = 0;
      end else begin
         if (st && m_scnt < SAT) m_scnt++;
         if (x.v && !st && tracked(x)) begin
            ready_at[x.rd] = now_c + 1 + l;
            if (l >= 2) resv[now_c + l] = 1'b1;
         end
      end
      now_c++;
      #1;
      dut_st = bus.stall;
   endtask

   // Present x, holding it while the DUT stalls; reports number of stalled cycles
   task automatic issue_hold(input ins_t x, input int unsigned max_cyc, output int unsigned nst);
      bit st;
      nst = 0;
      for (int unsigned k = 0; k < max_cyc; k++) begin
         step(x, 1'b1, 1'b1, st);
         if (!st) return;
         nst++;
      end
      chk("hold_timeout", nst, 32'hFFFF_FFFF);
   endtask

   task automatic idle(input int unsigned n);
      bit st;
      for (int unsigned k = 0; k < n; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, st);
   endtask

   // Monitor: compare every cycle's outputs against the queued prediction
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall",        32'(bus.stall),        32'(e.stall));
         chk("pc_write",     32'(bus.pc_write),     32'(!e.stall));
         chk("ifid_write",   32'(bus.ifid_write),   32'(!e.stall));
         chk("idex_bubble",  32'(bus.idex_bubble),  32'(e.stall));
         chk("pending_mask", 32'(bus.pending_mask), e.pend);
         chk("stall_count",  32'(bus.stall_count),  e.scnt);
      end
   end

   initial begin
      bit          st;
      int unsigned nst;
      ins_t        cur;
      bit          cur_st;

      reset = 1'b0;
      bus.issue_valid = 1'b0; bus.issue_rs = '0; bus.issue_rt = '0;
      bus.issue_use_rs = 1'b0; bus.issue_use_rt = 1'b0; bus.issue_we = 1'b0;
      bus.issue_rd = '0; bus.issue_lat = '0;
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, st);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);

      // Reader with nothing pending
      step(mk(1, 3, 0, 1, 0, 0, 0, 0), 1'b1, 1'b1, st);
      chk("idle_reader_stall", 32'(st), 32'd0);

      // RAW on a 3-cycle result
      step(mk(1, 0, 0, 0, 0, 1, 5, 3), 1'b1, 1'b1, st);
      issue_hold(mk(1, 0, 5, 0, 1, 0, 0, 0), 20, nst);
      chk("raw_lat3_stalls", nst, 32'd3);
      chk("raw_stall_count", 32'(bus.stall_count), 32'd3);
      idle(10);

      // WAW: older lat 6 vs younger lat 2
      step(mk(1, 0, 0, 0, 0, 1, 7, 6), 1'b1, 1'b1, st);
      issue_hold(mk(1, 0, 0, 0, 0, 1, 7, 2), 20, nst);
      chk("waw_stalls", nst, 32'd4);
      idle(10);

      // Writeback port collision
      step(mk(1, 0, 0, 0, 0, 1, 2, 4), 1'b1, 1'b1, st);
      issue_hold(mk(1, 0, 0, 0, 0, 1, 9, 3), 20, nst);
      chk("port_stalls", nst, 32'd1);
      idle(10);

      // Untracked writes and latency clamp
      step(mk(1, 0, 0, 0, 0, 1, 0, 3), 1'b1, 1'b1, st);
      issue_hold(mk(1, 0, 0, 1, 1, 0, 0, 0), 20, nst);
      chk("r0_reader_stalls", nst, 32'd0);
      step(mk(1, 0, 0, 0, 0, 1, 6, 0), 1'b1, 1'b1, st);
      issue_hold(mk(1, 6, 0, 1, 0, 0, 0, 0), 20, nst);
      chk("lat0_reader_stalls", nst, 32'd0);
      step(mk(1, 0, 0, 0, 0, 1, 10, 12), 1'b1, 1'b1, st);
      issue_hold(mk(1, 0, 10, 0, 1, 0, 0, 0), 20, nst);
      chk("lat12_clamped_stalls", nst, 32'd8);
      idle(10);

      // Reset mid-flight discards pending results
      step(mk(1, 0, 0, 0, 0, 1, 4, 5), 1'b1, 1'b1, st);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, st);
      issue_hold(mk(1, 4, 0, 1, 0, 0, 0, 0), 20, nst);
      chk("post_reset_reader_stalls", nst, 32'd0);
      chk("post_reset_pending", 32'(bus.pending_mask), 32'd0);

      // Drive stall counter into saturation
      for (int k = 0; k < 140; k++) begin
         step(mk(1, 0, 0, 0, 0, 1, 1, 8), 1'b1, 1'b1, st);
         issue_hold(mk(1, 1, 0, 1, 0, 0, 0, 0), 20, nst);
      end
      idle(2);
      chk("stall_count_saturated", 32'(bus.stall_count), SAT);

      // Random traffic, instruction held while stalled
      cur    = mk(0, 0, 0, 0, 0, 0, 0, 0);
      cur_st = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         bit rst_n;
         if (!cur_st) begin
            cur = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 12));
         end
         rst_n  = ($urandom_range(0, 299) != 0);
         cur_st = m_stall(cur) && rst_n;
         step(cur, rst_n, 1'b1, st);
      end

      idle(2);
      @(negedge clock);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
